// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame constants and the parity helper
// used by both the transmit and receive paths.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4,
    TX_BREAK  = 3'd5,
    TX_MARK   = 3'd6
  } uart_tx_state_e;

  // Even parity when odd=0: result makes the total count of ones even.
  function automatic logic parity_calc(input logic [UART_DATA_BITS-1:0] data,
                                       input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter: reloads with divisor-1 on load or at terminal count,
// flags bit_end while the count sits at zero. A divisor of 0 behaves as 1.
module uart_baud_counter #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 load,
  output logic                 bit_end,
  output logic                 bit_end_next
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic [DIV_WIDTH-1:0] reload;

  always_comb begin
    reload = (divisor == '0) ? '0 : divisor - DIV_WIDTH'(1);
    if (load || (cnt_q == '0)) begin
      cnt_d = reload;
    end else begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end      = (cnt_q == '0);
  // Lets the parent register outputs that must line up with the final cycle of a bit.
  assign bit_end_next = (cnt_d == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises bytes (start, 8 data LSB-first, optional parity,
// 1 or 2 stop bits) and generates line breaks followed by a one-bit mark.
//
// state     | meaning
// TX_IDLE   | line high, waiting for a byte or a break request
// TX_START  | start bit, line low
// TX_DATA   | data bits, LSB first
// TX_PARITY | parity bit
// TX_STOP   | one or two stop bits, line high
// TX_BREAK  | line held low for at least BREAK_MIN_BIT_PERIODS bit periods
// TX_MARK   | one bit period of mark after a break
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH             = 16,
  parameter int BREAK_MIN_BIT_PERIODS = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIV_WIDTH-1:0]      clks_per_bit,
  input  logic                      parity_en,
  input  logic                      parity_odd,
  input  logic                      two_stop,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  input  logic                      break_req,
  output logic                      tx,
  output logic                      tx_busy,
  output logic                      break_active,
  output logic                      frame_done
);

  localparam int BRK_W = (BREAK_MIN_BIT_PERIODS < 1) ? 1 : $clog2(BREAK_MIN_BIT_PERIODS + 1);
  localparam logic [BRK_W-1:0] BRK_MIN = BRK_W'(BREAK_MIN_BIT_PERIODS);

  uart_tx_state_e            state_q, state_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]                idx_q, idx_d;
  logic                      par_q, par_d;
  logic                      pe_q, pe_d;
  logic                      ts_q, ts_d;
  logic                      stop2_q, stop2_d;
  logic [DIV_WIDTH-1:0]      div_q, div_d;
  logic [BRK_W-1:0]          brk_cnt_q, brk_cnt_d;
  logic [BRK_W:0]            brk_inc;

  logic tx_q, tx_d;
  logic tx_ready_q, tx_ready_d;
  logic tx_busy_q, tx_busy_d;
  logic break_active_q, break_active_d;
  logic frame_done_q, frame_done_d;

  logic                 cnt_load;
  logic [DIV_WIDTH-1:0] cnt_div;
  logic                 bit_end;
  logic                 bit_end_next;

  uart_baud_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk          (clk),
    .rst          (rst),
    .divisor      (cnt_div),
    .load         (cnt_load),
    .bit_end      (bit_end),
    .bit_end_next (bit_end_next)
  );

  // Live divisor only matters when leaving IDLE; afterwards the latched copy rules.
  assign cnt_div = (state_q == TX_IDLE) ? clks_per_bit : div_q;
  assign brk_inc = {1'b0, brk_cnt_q} + (BRK_W + 1)'(1);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    par_d     = par_q;
    pe_d      = pe_q;
    ts_d      = ts_q;
    stop2_d   = stop2_q;
    div_d     = div_q;
    brk_cnt_d = brk_cnt_q;
    cnt_load  = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        if (break_req) begin
          state_d   = TX_BREAK;
          cnt_load  = 1'b1;
          div_d     = clks_per_bit;
          brk_cnt_d = '0;
        end else if (tx_valid && tx_ready_q) begin
          state_d  = TX_START;
          cnt_load = 1'b1;
          div_d    = clks_per_bit;
          shreg_d  = tx_data;
          idx_d    = '0;
          par_d    = parity_calc(tx_data, parity_odd);
          pe_d     = parity_en;
          ts_d     = two_stop;
        end
      end
      TX_START: begin
        if (bit_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = pe_q ? TX_PARITY : TX_STOP;
            stop2_d = 1'b0;
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) begin
          state_d = TX_STOP;
          stop2_d = 1'b0;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (ts_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d   = break_req ? TX_BREAK : TX_IDLE;
            brk_cnt_d = '0;
          end
        end
      end
      TX_BREAK: begin
        if (bit_end) begin
          if (brk_cnt_q != BRK_MIN) brk_cnt_d = brk_inc[BRK_W-1:0];
          if ((brk_inc >= {1'b0, BRK_MIN}) && !break_req) state_d = TX_MARK;
        end
      end
      TX_MARK: begin
        if (bit_end) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      TX_START, TX_BREAK: tx_d = 1'b0;
      TX_DATA:            tx_d = shreg_d[0];
      TX_PARITY:          tx_d = par_d;
      default:            tx_d = 1'b1;
    endcase
    tx_ready_d     = (state_d == TX_IDLE) && !break_req;
    tx_busy_d      = (state_d != TX_IDLE);
    break_active_d = (state_d == TX_BREAK);
    frame_done_d   = (state_d == TX_STOP) && (!ts_d || stop2_d) && bit_end_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= TX_IDLE;
      shreg_q        <= '0;
      idx_q          <= '0;
      par_q          <= 1'b0;
      pe_q           <= 1'b0;
      ts_q           <= 1'b0;
      stop2_q        <= 1'b0;
      div_q          <= '0;
      brk_cnt_q      <= '0;
      tx_q           <= 1'b1;
      tx_ready_q     <= 1'b0;
      tx_busy_q      <= 1'b0;
      break_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      idx_q          <= idx_d;
      par_q          <= par_d;
      pe_q           <= pe_d;
      ts_q           <= ts_d;
      stop2_q        <= stop2_d;
      div_q          <= div_d;
      brk_cnt_q      <= brk_cnt_d;
      tx_q           <= tx_d;
      tx_ready_q     <= tx_ready_d;
      tx_busy_q      <= tx_busy_d;
      break_active_q <= break_active_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_ready     = tx_ready_q;
  assign tx_busy      = tx_busy_q;
  assign break_active = break_active_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed and random frames compared
// cycle by cycle against a bit-list model of the serial line.
module tb_uart_tx_engine;

  localparam int MIN_BRK = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] clks_per_bit = 16'd4;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        two_stop = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        break_req = 1'b0;
  logic        tx, tx_ready, tx_busy, break_active, frame_done;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_engine #(
    .DIV_WIDTH             (16),
    .BREAK_MIN_BIT_PERIODS (MIN_BRK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clks_per_bit (clks_per_bit),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .two_stop     (two_stop),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .break_req    (break_req),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .break_active (break_active),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Present a byte and wait (bounded) until it is accepted; returns just after the capture edge.
  task automatic accept(input logic [7:0] d, input logic pe, input logic po, input logic ts,
                        input logic [15:0] cpb, input bit hold, input string tag);
    bit ok = 0;
    tx_data = d; parity_en = pe; parity_odd = po; two_stop = ts; clks_per_bit = cpb;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      if (tx_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      tx_valid     = 1'b0;
      tx_data      = 8'($urandom);
      parity_en    = 1'($urandom);
      parity_odd   = 1'($urandom);
      two_stop     = 1'($urandom);
      clks_per_bit = 16'($urandom_range(0, 9));
    end
  endtask

  // Model: list of bit values, each stretched to the bit period; checks every line cycle.
  task automatic check_frame(input logic [7:0] d, input logic pe, input logic po, input logic ts,
                             input logic [15:0] cpb, input int brk_at, input string tag);
    logic bits[$];
    logic line[$];
    int per, werr, busy_err, fd_at, fd_cnt;
    per = (cpb == 16'd0) ? 1 : int'(cpb);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(1'(($countones(d) + int'(po)) % 2));
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    foreach (bits[i]) for (int r = 0; r < per; r++) line.push_back(bits[i]);
    werr = 0; busy_err = 0; fd_at = -1; fd_cnt = 0;
    for (int k = 0; k < line.size(); k++) begin
      @(negedge clk);
      if (tx !== line[k]) werr++;
      if (tx_busy !== 1'b1) busy_err++;
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_at = k;
      end
      if (k == brk_at) break_req = 1'b1;
    end
    chk({tag, "_line_errs"}, 32'(werr), 32'd0);
    chk({tag, "_done_at"}, 32'(fd_at), 32'(line.size() - 1));
    chk({tag, "_done_cnt"}, 32'(fd_cnt), 32'd1);
    chk({tag, "_busy_errs"}, 32'(busy_err), 32'd0);
  endtask

  task automatic post_idle(input string tag);
    @(negedge clk);
    chk({tag, "_idle_rdy_busy_tx"}, {29'd0, tx_ready, tx_busy, tx}, 32'b101);
  endtask

  // Starts at the first expected low cycle; releases break_req at cycle drop_at.
  task automatic measure_break(input int per, input int drop_at, input string tag);
    int low = 0, act = 0, mark = 0, rdy = 0;
    bit done = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (tx_busy !== 1'b1) begin
        done = 1;
        rdy  = int'(tx_ready);
        break;
      end
      if (tx === 1'b0) low++;
      else mark++;
      if (break_active === 1'b1) act++;
      if (i == drop_at) break_req = 1'b0;
    end
    chk({tag, "_ended"}, 32'(done), 32'd1);
    chk({tag, "_low_cycles"}, 32'(low), 32'(MIN_BRK * per));
    chk({tag, "_active_cycles"}, 32'(act), 32'(MIN_BRK * per));
    chk({tag, "_mark_cycles"}, 32'(mark), 32'(per));
    chk({tag, "_ready_after"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    logic [7:0]  rd;
    logic        rpe, rpo, rts;
    logic [15:0] rcpb;
    int          bad;

    // Reset values, then ready one cycle after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {27'd0, tx, tx_ready, tx_busy, break_active, frame_done}, 32'b10000);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", {29'd0, tx_ready, tx_busy, tx}, 32'b101);

    // 0x55, no parity, 1 stop, 4 cycles/bit
    accept(8'h55, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, "f55");
    check_frame(8'h55, 1'b0, 1'b0, 1'b0, 16'd4, -1, "f55");
    post_idle("f55");

    // 0x07 even then odd parity, 2 stop, 8 cycles/bit
    accept(8'h07, 1'b1, 1'b0, 1'b1, 16'd8, 1'b0, "f07e");
    check_frame(8'h07, 1'b1, 1'b0, 1'b1, 16'd8, -1, "f07e");
    accept(8'h07, 1'b1, 1'b1, 1'b1, 16'd8, 1'b0, "f07o");
    check_frame(8'h07, 1'b1, 1'b1, 1'b1, 16'd8, -1, "f07o");
    post_idle("f07o");

    // Back-to-back with tx_valid held; config changed while first frame is in flight
    accept(8'hA5, 1'b0, 1'b0, 1'b0, 16'd4, 1'b1, "b2b1");
    tx_data = 8'h3C; parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b0;
    check_frame(8'hA5, 1'b0, 1'b0, 1'b0, 16'd4, -1, "b2b1");
    @(negedge clk);
    chk("b2b_gap_cycle", {29'd0, tx_ready, tx_busy, tx}, 32'b101);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check_frame(8'h3C, 1'b1, 1'b0, 1'b0, 16'd4, -1, "b2b2");
    post_idle("b2b2");

    // Short break request in IDLE still produces the minimum-length break
    clks_per_bit = 16'd4;
    break_req = 1'b1;
    @(posedge clk);
    #1;
    measure_break(4, 1, "brk_idle");

    // Break requested mid-DATA: frame completes intact, then the break
    accept(8'hC3, 1'b1, 1'b0, 1'b1, 16'd3, 1'b0, "brk_mid");
    check_frame(8'hC3, 1'b1, 1'b0, 1'b1, 16'd3, 12, "brk_mid");
    measure_break(3, 2, "brk_mid");

    // Simultaneous tx_valid and break_req in IDLE: break wins, byte not taken
    @(negedge clk);
    clks_per_bit = 16'd2;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    break_req = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    measure_break(2, 1, "brk_vs_valid");

    // Reset in the middle of DATA
    accept(8'h5A, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, "rst_mid");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_outputs", {27'd0, tx, tx_ready, tx_busy, break_active, frame_done}, 32'b10000);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_release", {29'd0, tx_ready, tx_busy, tx}, 32'b101);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("rst_mid_no_resume", 32'(bad), 32'd0);

    // clks_per_bit = 0 behaves as one cycle per bit
    accept(8'h96, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, "cpb0");
    check_frame(8'h96, 1'b1, 1'b1, 1'b0, 16'd0, -1, "cpb0");
    post_idle("cpb0");

    // Random frames, chained
    for (int n = 0; n < 12; n++) begin
      rd   = 8'($urandom);
      rpe  = 1'($urandom);
      rpo  = 1'($urandom);
      rts  = 1'($urandom);
      rcpb = 16'($urandom_range(0, 6));
      accept(rd, rpe, rpo, rts, rcpb, 1'b0, "rand");
      check_frame(rd, rpe, rpo, rts, rcpb, -1, "rand");
    end
    post_idle("rand_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
